dflow_replay_engine: RTL and testbench

Parametrised store-and-replay core for dflow tuples, running entirely in the qdr_clk domain behind the clock-crossing FIFOs of the dflow generator top. In STORE mode it packs incoming tuples into consecutive QDR words inside a programmable address window. In REPLAY mode it reads the window back in order, with these additions:
- programmable loop count;
- programmable inter-tuple gap;
- credit-based output buffering that absorbs QDR read latency.

---
 rtl/dflow_replay_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_dflow_replay_engine.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dflow_replay_engine.sv
// dflow_replay_engine: stores dflow tuples into a QDR address window
// and replays them with loop count, gap and credit-based output buffering.
module dflow_replay_engine #(
  parameter int TUPLE_WIDTH    = 120,
  parameter int QDR_DATA_WIDTH = 144,
  parameter int QDR_ADDR_WIDTH = 19,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                      qdr_clk,
  input  logic                      resetn,
  input  logic                      sw_rst,
  input  logic                      start_store,
  input  logic                      start_replay,
  input  logic                      stop,
  input  logic [15:0]               loop_count,
  input  logic [15:0]               gap_cycles,
  input  logic [QDR_ADDR_WIDTH-1:0] mem_addr_low,
  input  logic [QDR_ADDR_WIDTH-1:0] mem_addr_high,
  input  logic                      init_calib_complete,
  output logic                      user_app_wr_cmd,
  output logic [QDR_ADDR_WIDTH-1:0] user_app_wr_addr,
  output logic [QDR_DATA_WIDTH-1:0] user_app_wr_data,
  output logic                      user_app_rd_cmd,
  output logic [QDR_ADDR_WIDTH-1:0] user_app_rd_addr,
  input  logic                      user_app_rd_valid,
  input  logic [QDR_DATA_WIDTH-1:0] user_app_rd_data,
  input  logic [TUPLE_WIDTH-1:0]    tuple_in_data,
  input  logic                      tuple_in_vld,
  output logic                      tuple_in_ready,
  output logic [TUPLE_WIDTH-1:0]    tuple_out_data,
  output logic                      tuple_out_vld,
  input  logic                      tuple_out_ready,
  output logic                      busy,
  output logic [QDR_ADDR_WIDTH:0]   stored_count,
  output logic [15:0]               loops_done,
  output logic                      overflow
);

  localparam int AW = QDR_ADDR_WIDTH;
  localparam int DW = QDR_DATA_WIDTH;
  localparam int TW = TUPLE_WIDTH;
  localparam int FW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    REPLAY,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic            start_store_q, start_replay_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     stored_count_q, stored_count_d;
  logic            wr_cmd_q, wr_cmd_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            rd_cmd_q, rd_cmd_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]     loops_done_q, loops_done_d;
  logic [15:0]     gap_q, gap_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            rd_armed_q, rd_armed_d;
  logic            overflow_q, overflow_d;
  logic [FW:0]     fifo_wp_q, fifo_wp_d;
  logic [FW:0]     fifo_rp_q, fifo_rp_d;
  logic [TW-1:0]   fifo_mem [OUT_FIFO_DEPTH];

  logic            store_rise, replay_rise;
  logic            accept, issue, wrap;
  logic            fifo_empty, fifo_full;
  logic            push, push_ok, pop;
  logic [AW-1:0]   last_addr;
  logic [15:0]     loops_inc;

  // Handshake and condition decode shared by the FSM and datapath
  always_comb begin
    store_rise  = start_store & ~start_store_q;
    replay_rise = start_replay & ~start_replay_q;
    fifo_empty  = (fifo_wp_q == fifo_rp_q);
    fifo_full   = (fifo_wp_q[FW] != fifo_rp_q[FW]) &&
                  (fifo_wp_q[FW-1:0] == fifo_rp_q[FW-1:0]);
    pop         = ~fifo_empty & tuple_out_ready;
    push        = user_app_rd_valid & rd_armed_q;
    push_ok     = push & ~fifo_full;
    accept      = (state_q == STORE) & tuple_in_vld;
    issue       = (state_q == REPLAY) & (credits_q != '0) &
                  (gap_q == '0) & ~stop;
    last_addr   = mem_addr_low + stored_count_q[AW-1:0] - AW'(1);
    wrap        = (rd_ptr_q == last_addr);
    loops_inc   = loops_done_q + 16'd1;
  end

  // Next-state, pointer, credit and command computation
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    stored_count_d = stored_count_q;
    wr_cmd_d       = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    rd_ptr_d       = rd_ptr_q;
    rd_cmd_d       = 1'b0;
    rd_addr_d      = rd_addr_q;
    loops_done_d   = loops_done_q;
    gap_d          = (gap_q == '0) ? gap_q : gap_q - 16'd1;
    credits_d      = credits_q + CW'(pop) - CW'(issue);
    rd_armed_d     = rd_armed_q | issue;
    overflow_d     = overflow_q | (push & fifo_full);
    fifo_wp_d      = fifo_wp_q + (FW+1)'(push_ok);
    fifo_rp_d      = fifo_rp_q + (FW+1)'(pop);

    unique case (state_q)
      IDLE: begin
        if (store_rise) begin
          if (init_calib_complete &&
              mem_addr_high >= mem_addr_low) begin
            state_d        = STORE;
            wr_ptr_d       = mem_addr_low;
            stored_count_d = '0;
          end
        end else if (replay_rise && init_calib_complete &&
                     stored_count_q != '0) begin
          state_d      = REPLAY;
          rd_ptr_d     = mem_addr_low;
          loops_done_d = '0;
          credits_d    = FULL_CREDITS;
          gap_d        = '0;
        end
      end
      STORE: begin
        if (accept) begin
          wr_cmd_d       = 1'b1;
          wr_addr_d      = wr_ptr_q;
          wr_data_d      = DW'(tuple_in_data);
          wr_ptr_d       = wr_ptr_q + AW'(1);
          stored_count_d = stored_count_q + (AW+1)'(1);
        end
        if (!start_store ||
            (accept && wr_ptr_q == mem_addr_high)) begin
          state_d = IDLE;
        end
      end
      REPLAY: begin
        if (issue) begin
          rd_cmd_d  = 1'b1;
          rd_addr_d = rd_ptr_q;
          gap_d     = gap_cycles;
          if (wrap) begin
            rd_ptr_d     = mem_addr_low;
            loops_done_d = loops_inc;
            if (loop_count != '0 && loops_inc == loop_count) begin
              state_d = DRAIN;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
        if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // full credits means nothing in flight and the FIFO is empty
        if (credits_q == FULL_CREDITS) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; resetn and sw_rst act identically
  always_ff @(posedge qdr_clk) begin
    if (!resetn || sw_rst) begin
      state_q        <= IDLE;
      start_store_q  <= 1'b0;
      start_replay_q <= 1'b0;
      wr_ptr_q       <= '0;
      stored_count_q <= '0;
      wr_cmd_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_ptr_q       <= '0;
      rd_cmd_q       <= 1'b0;
      rd_addr_q      <= '0;
      loops_done_q   <= '0;
      gap_q          <= '0;
      credits_q      <= FULL_CREDITS;
      rd_armed_q     <= 1'b0;
      overflow_q     <= 1'b0;
      fifo_wp_q      <= '0;
      fifo_rp_q      <= '0;
    end else begin
      state_q        <= state_d;
      start_store_q  <= start_store;
      start_replay_q <= start_replay;
      wr_ptr_q       <= wr_ptr_d;
      stored_count_q <= stored_count_d;
      wr_cmd_q       <= wr_cmd_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_cmd_q       <= rd_cmd_d;
      rd_addr_q      <= rd_addr_d;
      loops_done_q   <= loops_done_d;
      gap_q          <= gap_d;
      credits_q      <= credits_d;
      rd_armed_q     <= rd_armed_d;
      overflow_q     <= overflow_d;
      fifo_wp_q      <= fifo_wp_d;
      fifo_rp_q      <= fifo_rp_d;
    end
  end

  // Output FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge qdr_clk) begin
    if (push_ok) begin
      fifo_mem[fifo_wp_q[FW-1:0]] <= user_app_rd_data[TW-1:0];
    end
  end

  if (DW > TW) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^user_app_rd_data[DW-1:TW];
  end

  assign user_app_wr_cmd  = wr_cmd_q;
  assign user_app_wr_addr = wr_addr_q;
  assign user_app_wr_data = wr_data_q;
  assign user_app_rd_cmd  = rd_cmd_q;
  assign user_app_rd_addr = rd_addr_q;
  assign tuple_in_ready   = (state_q == STORE);
  assign tuple_out_vld    = ~fifo_empty;
  assign tuple_out_data   = fifo_empty ? '0 :
                            fifo_mem[fifo_rp_q[FW-1:0]];
  assign busy             = (state_q != IDLE);
  assign stored_count     = stored_count_q;
  assign loops_done       = loops_done_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_dflow_replay_engine.sv
// tb_dflow_replay_engine: scoreboard bench with a QDR memory model
// returning reads after a configurable latency.
module tb_dflow_replay_engine;

  localparam int TW = 120;
  localparam int DW = 144;
  localparam int AW = 19;
  localparam int DEPTH = 16;
  localparam logic [AW-1:0] AMAX = '1;

  logic          qdr_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sw_rst = 1'b0;
  logic          start_store = 1'b0;
  logic          start_replay = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   loop_count = '0;
  logic [15:0]   gap_cycles = '0;
  logic [AW-1:0] mem_addr_low = '0;
  logic [AW-1:0] mem_addr_high = '0;
  logic          init_calib_complete = 1'b1;
  logic          user_app_wr_cmd;
  logic [AW-1:0] user_app_wr_addr;
  logic [DW-1:0] user_app_wr_data;
  logic          user_app_rd_cmd;
  logic [AW-1:0] user_app_rd_addr;
  logic          user_app_rd_valid = 1'b0;
  logic [DW-1:0] user_app_rd_data = '0;
  logic [TW-1:0] tuple_in_data = '0;
  logic          tuple_in_vld = 1'b0;
  logic          tuple_in_ready;
  logic [TW-1:0] tuple_out_data;
  logic          tuple_out_vld;
  logic          tuple_out_ready = 1'b0;
  logic          busy;
  logic [AW:0]   stored_count;
  logic [15:0]   loops_done;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] qmem [int];
  rd_t           pend [$];
  wr_t           obs_wr [$];
  wr_t           exp_wr [$];
  logic [TW-1:0] obs_out [$];
  logic [TW-1:0] exp_out [$];
  int            rd_times [$];
  int            cyc = 0;
  int            rd_lat = 7;
  int            passed = 0;
  int            total = 0;

  dflow_replay_engine dut (
    .qdr_clk(qdr_clk), .resetn(resetn), .sw_rst(sw_rst),
    .start_store(start_store), .start_replay(start_replay),
    .stop(stop), .loop_count(loop_count),
    .gap_cycles(gap_cycles), .mem_addr_low(mem_addr_low),
    .mem_addr_high(mem_addr_high),
    .init_calib_complete(init_calib_complete),
    .user_app_wr_cmd(user_app_wr_cmd),
    .user_app_wr_addr(user_app_wr_addr),
    .user_app_wr_data(user_app_wr_data),
    .user_app_rd_cmd(user_app_rd_cmd),
    .user_app_rd_addr(user_app_rd_addr),
    .user_app_rd_valid(user_app_rd_valid),
    .user_app_rd_data(user_app_rd_data),
    .tuple_in_data(tuple_in_data), .tuple_in_vld(tuple_in_vld),
    .tuple_in_ready(tuple_in_ready),
    .tuple_out_data(tuple_out_data), .tuple_out_vld(tuple_out_vld),
    .tuple_out_ready(tuple_out_ready), .busy(busy),
    .stored_count(stored_count), .loops_done(loops_done),
    .overflow(overflow)
  );

  always #5 qdr_clk = ~qdr_clk;

  // QDR model and output monitor, evaluated away from the active edge
  always @(negedge qdr_clk) begin : qdr_model
    wr_t w;
    rd_t r;
    cyc++;
    if (user_app_wr_cmd) begin
      qmem[int'(user_app_wr_addr)] = user_app_wr_data;
      w.a = user_app_wr_addr;
      w.d = user_app_wr_data;
      obs_wr.push_back(w);
    end
    if (user_app_rd_cmd) begin
      rd_times.push_back(cyc);
      r.due = cyc + rd_lat;
      r.d = qmem.exists(int'(user_app_rd_addr)) ?
            qmem[int'(user_app_rd_addr)] : '0;
      pend.push_back(r);
    end
    if (tuple_out_vld && tuple_out_ready)
      obs_out.push_back(tuple_out_data);
    user_app_rd_valid = 1'b0;
    user_app_rd_data = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      user_app_rd_valid = 1'b1;
      user_app_rd_data = r.d;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge qdr_clk);
    #1;
  endtask

  task automatic store_run(input logic [AW-1:0] lo,
                           input logic [AW-1:0] hi,
                           input int offer, input int exp_n,
                           input int base, input bit drop_last,
                           output int acc);
    wr_t w;
    mem_addr_low = lo;
    mem_addr_high = hi;
    for (int i = 0; i < exp_n; i++) begin
      w.a = lo + AW'(i);
      w.d = DW'(base + i);
      exp_wr.push_back(w);
    end
    start_store = 1'b1;
    tick(2);
    acc = 0;
    for (int i = 0; i < offer; i++) begin
      int spins = 0;
      bit done = 1'b0;
      tuple_in_data = TW'(base + i);
      tuple_in_vld = 1'b1;
      if (drop_last && i == offer - 1) start_store = 1'b0;
      while (!done && spins < 8) begin
        done = tuple_in_ready;
        tick(1);
        spins++;
      end
      if (done) acc++;
    end
    tuple_in_vld = 1'b0;
    tuple_in_data = '0;
  endtask

  task automatic pulse_replay;
    start_replay = 1'b1;
    tick(2);
    start_replay = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(3);
    total++;
    if ({busy, tuple_in_ready, overflow, tuple_out_vld,
         user_app_wr_cmd, user_app_rd_cmd} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000",
               {busy, tuple_in_ready, overflow, tuple_out_vld,
                user_app_wr_cmd, user_app_rd_cmd});
    else passed++;
    total++;
    if ({stored_count, loops_done} !== '0)
      $display("FAIL reset_counts got %h/%h want 0",
               stored_count, loops_done);
    else passed++;
    total++;
    if ({user_app_wr_addr, user_app_wr_data, user_app_rd_addr,
         tuple_out_data} !== '0)
      $display("FAIL reset_buses got %h/%h/%h/%h want 0",
               user_app_wr_addr, user_app_wr_data,
               user_app_rd_addr, tuple_out_data);
    else passed++;
    resetn = 1'b1;
    tick(2);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_store_window_full;
    int acc;
    wr_t e, o;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) store_run(AW'(0), AW'(3), 6, 4, 'h100, 1'b0, acc);
      else store_run(AMAX - AW'(1), AMAX, 3, 2, 'h200, 1'b0, acc);
      total++;
      if (acc !== (s == 0 ? 4 : 2))
        $display("FAIL full_accepted got %0d want %0d", acc, s == 0 ? 4 : 2);
      else passed++;
      total++;
      if ({busy, tuple_in_ready} !== 2'b00)
        $display("FAIL full_idle got %b want 00", {busy, tuple_in_ready});
      else passed++;
      total++;
      if (stored_count !== (AW+1)'(s == 0 ? 4 : 2))
        $display("FAIL full_count got %0d want %0d",
                 stored_count, s == 0 ? 4 : 2);
      else passed++;
      start_store = 1'b0;
      tick(2);
      total++;
      if (obs_wr.size() !== exp_wr.size())
        $display("FAIL full_nwr got %0d want %0d",
                 obs_wr.size(), exp_wr.size());
      else passed++;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
        e = exp_wr.pop_front();
        o = obs_wr.pop_front();
        total++;
        if (o !== e)
          $display("FAIL full_wr got %h:%h want %h:%h", o.a, o.d, e.a, e.d);
        else passed++;
      end
      exp_wr.delete();
      obs_wr.delete();
    end
  endtask

  task automatic test_store;
    int acc;
    wr_t e, o;
    store_run(AW'('h10), AW'('h1F), 5, 5, 1, 1'b1, acc);
    total++;
    if (acc !== 5) $display("FAIL store_accepted got %0d want 5", acc);
    else passed++;
    tick(2);
    total++;
    if (busy !== 1'b0) $display("FAIL store_end_idle got %b want 0", busy);
    else passed++;
    total++;
    if (stored_count !== (AW+1)'(5))
      $display("FAIL store_count got %0d want 5", stored_count);
    else passed++;
    total++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL store_nwr got %0d want %0d",
               obs_wr.size(), exp_wr.size());
    else passed++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front();
      o = obs_wr.pop_front();
      total++;
      if (o !== e)
        $display("FAIL store_wr got %h:%h want %h:%h", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_wr.delete();
    obs_wr.delete();
  endtask

  task automatic test_replay_loops;
    int r0, n;
    logic [TW-1:0] e, o;
    loop_count = 16'd3;
    gap_cycles = '0;
    tuple_out_ready = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int i = 1; i <= 5; i++) exp_out.push_back(TW'(i));
    r0 = rd_times.size();
    pulse_replay();
    total++;
    if (busy !== 1'b1) $display("FAIL replay_busy got %b want 1", busy);
    else passed++;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    total++;
    if (busy !== 1'b0) $display("FAIL replay_timeout got busy %b want 0", busy);
    else passed++;
    total++;
    if (obs_out.size() !== 15)
      $display("FAIL replay_nout got %0d want 15", obs_out.size());
    else passed++;
    while (exp_out.size() > 0 && obs_out.size() > 0) begin
      e = exp_out.pop_front();
      o = obs_out.pop_front();
      total++;
      if (o !== e) $display("FAIL replay_data got %0h want %0h", o, e);
      else passed++;
    end
    exp_out.delete();
    obs_out.delete();
    total++;
    if (loops_done !== 16'd3)
      $display("FAIL replay_loops got %0d want 3", loops_done);
    else passed++;
    total++;
    if (rd_times.size() - r0 !== 15)
      $display("FAIL replay_nrd got %0d want 15", rd_times.size() - r0);
    else passed++;
  endtask

  task automatic test_backpressure;
    int r0, n;
    logic [TW-1:0] e, o;
    loop_count = 16'd4;
    tuple_out_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int i = 1; i <= 5; i++) exp_out.push_back(TW'(i));
    r0 = rd_times.size();
    pulse_replay();
    tick(100);
    total++;
    if (rd_times.size() - r0 !== DEPTH)
      $display("FAIL bp_nrd got %0d want %0d", rd_times.size() - r0, DEPTH);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL bp_overflow got %b want 0", overflow);
    else passed++;
    total++;
    if ({tuple_out_vld, tuple_out_data} !== {1'b1, TW'(1)})
      $display("FAIL bp_head got %b/%0h want 1/1",
               tuple_out_vld, tuple_out_data);
    else passed++;
    tuple_out_ready = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    total++;
    if (obs_out.size() !== 20)
      $display("FAIL bp_nout got %0d want 20", obs_out.size());
    else passed++;
    while (exp_out.size() > 0 && obs_out.size() > 0) begin
      e = exp_out.pop_front();
      o = obs_out.pop_front();
      total++;
      if (o !== e) $display("FAIL bp_data got %0h want %0h", o, e);
      else passed++;
    end
    exp_out.delete();
    obs_out.delete();
    total++;
    if ({busy, loops_done, overflow} !== {1'b0, 16'd4, 1'b0})
      $display("FAIL bp_end got %b/%0d/%b want 0/4/0",
               busy, loops_done, overflow);
    else passed++;
  endtask

  task automatic test_gap_stop;
    int r0, n, nrd;
    logic [TW-1:0] e, o;
    loop_count = '0;
    gap_cycles = 16'd4;
    tuple_out_ready = 1'b1;
    for (int p = 0; p < 40; p++)
      for (int i = 1; i <= 5; i++) exp_out.push_back(TW'(i));
    r0 = rd_times.size();
    pulse_replay();
    tick(60);
    total++;
    if (rd_times.size() - r0 < 10)
      $display("FAIL gap_nrd got %0d want >=10", rd_times.size() - r0);
    else passed++;
    for (int i = r0 + 1; i < rd_times.size(); i++) begin
      total++;
      if (rd_times[i] - rd_times[i-1] !== 5)
        $display("FAIL gap_spacing got %0d want 5",
                 rd_times[i] - rd_times[i-1]);
      else passed++;
    end
    stop = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    stop = 1'b0;
    nrd = rd_times.size() - r0;
    total++;
    if (busy !== 1'b0) $display("FAIL stop_timeout got busy %b want 0", busy);
    else passed++;
    total++;
    if (obs_out.size() !== nrd)
      $display("FAIL stop_nout got %0d want %0d", obs_out.size(), nrd);
    else passed++;
    while (exp_out.size() > 0 && obs_out.size() > 0) begin
      e = exp_out.pop_front();
      o = obs_out.pop_front();
      total++;
      if (o !== e) $display("FAIL stop_data got %0h want %0h", o, e);
      else passed++;
    end
    exp_out.delete();
    obs_out.delete();
    total++;
    if (loops_done !== 16'(nrd / 5))
      $display("FAIL stop_loops got %0d want %0d", loops_done, nrd / 5);
    else passed++;
    gap_cycles = '0;
  endtask

  task automatic test_sw_rst;
    int r0;
    loop_count = '0;
    tuple_out_ready = 1'b1;
    pulse_replay();
    tick(3);
    sw_rst = 1'b1;
    tick(1);
    total++;
    if ({busy, tuple_in_ready, overflow, tuple_out_vld,
         user_app_wr_cmd, user_app_rd_cmd, stored_count, loops_done,
         tuple_out_data, user_app_wr_addr, user_app_wr_data,
         user_app_rd_addr} !== '0)
      $display("FAIL swrst_outputs got %b%b%b%b%b%b/%0h/%0h/%0h want 0",
               busy, tuple_in_ready, overflow, tuple_out_vld,
               user_app_wr_cmd, user_app_rd_cmd, stored_count,
               loops_done, tuple_out_data);
    else passed++;
    sw_rst = 1'b0;
    obs_out.delete();
    r0 = rd_times.size();
    tick(20);
    total++;
    if ({obs_out.size() != 0, tuple_out_vld, overflow, busy} !== 4'b0)
      $display("FAIL swrst_late got nout %0d vld %b ovf %b busy %b want 0",
               obs_out.size(), tuple_out_vld, overflow, busy);
    else passed++;
    total++;
    if (rd_times.size() !== r0)
      $display("FAIL swrst_nrd got %0d want %0d", rd_times.size(), r0);
    else passed++;
  endtask

  task automatic test_replay_empty;
    int r0;
    r0 = rd_times.size();
    pulse_replay();
    tick(5);
    total++;
    if ({busy, stored_count} !== '0)
      $display("FAIL empty_replay got busy %b count %0d want 0/0",
               busy, stored_count);
    else passed++;
    total++;
    if (rd_times.size() !== r0)
      $display("FAIL empty_nrd got %0d want %0d", rd_times.size(), r0);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_window_full();
    test_store();
    test_replay_loops();
    test_backpressure();
    test_gap_stop();
    test_sw_rst();
    test_replay_empty();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
